// File: rtl/axil_ram_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite slave among N native requesters.
// One transaction in flight at a time; the response is routed back to the granted requester.
module axil_ram_arbiter #(
   parameter int N          = 2,
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 16,
   parameter int STRB_WIDTH = DATA_WIDTH/8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [N-1:0]               req_valid,
   output logic [N-1:0]               req_ready,
   input  logic [N-1:0]               req_we,
   input  logic [N*ADDR_WIDTH-1:0]    req_addr,
   input  logic [N*DATA_WIDTH-1:0]    req_wdata,
   input  logic [N*STRB_WIDTH-1:0]    req_wstrb,
   output logic [N-1:0]               rsp_valid,
   input  logic [N-1:0]               rsp_ready,
   output logic [DATA_WIDTH-1:0]      rsp_rdata,
   output logic                       rsp_err,
   output logic [ADDR_WIDTH-1:0]      m_axil_awaddr,
   output logic [2:0]                 m_axil_awprot,
   output logic                       m_axil_awvalid,
   input  logic                       m_axil_awready,
   output logic [DATA_WIDTH-1:0]      m_axil_wdata,
   output logic [STRB_WIDTH-1:0]      m_axil_wstrb,
   output logic                       m_axil_wvalid,
   input  logic                       m_axil_wready,
   input  logic [1:0]                 m_axil_bresp,
   input  logic                       m_axil_bvalid,
   output logic                       m_axil_bready,
   output logic [ADDR_WIDTH-1:0]      m_axil_araddr,
   output logic [2:0]                 m_axil_arprot,
   output logic                       m_axil_arvalid,
   input  logic                       m_axil_arready,
   input  logic [DATA_WIDTH-1:0]      m_axil_rdata,
   input  logic [1:0]                 m_axil_rresp,
   input  logic                       m_axil_rvalid,
   output logic                       m_axil_rready
);

   localparam int GW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [2:0] {
      IDLE, WR_ISSUE, WR_RESP, RD_ISSUE, RD_DATA, RESP
   } state_t;

   state_t                 state_reg;
   logic [GW-1:0]          grant_reg;
   logic [GW-1:0]          last_reg;
   logic                   rsp_valid_reg;
   logic [GW-1:0]          sel_idx;
   logic                   sel_found;

   logic [ADDR_WIDTH-1:0]  addr_arr  [N];
   logic [DATA_WIDTH-1:0]  wdata_arr [N];
   logic [STRB_WIDTH-1:0]  wstrb_arr [N];

   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_lane
         assign addr_arr[gi]  = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
         assign wdata_arr[gi] = req_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
         assign wstrb_arr[gi] = req_wstrb[gi*STRB_WIDTH +: STRB_WIDTH];
         assign req_ready[gi] = (state_reg == IDLE) && sel_found && (sel_idx == GW'(gi));
         assign rsp_valid[gi] = rsp_valid_reg && (grant_reg == GW'(gi));
      end
   endgenerate

   // Search starts just past the last served requester so it drops to lowest priority.
   always_comb begin
      int            pos;
      logic [GW-1:0] cand;
      sel_idx   = '0;
      sel_found = 1'b0;
      pos       = 0;
      cand      = '0;
      for (int k = 1; k <= N; k++) begin
         pos = int'(last_reg) + k;
         if (pos >= N) pos = pos - N;
         cand = GW'(pos);
         if (!sel_found && req_valid[cand]) begin
            sel_found = 1'b1;
            sel_idx   = cand;
         end
      end
   end

   assign m_axil_awprot = 3'b000;
   assign m_axil_arprot = 3'b000;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= IDLE;
         grant_reg      <= '0;
         last_reg       <= GW'(N-1);
         rsp_valid_reg  <= 1'b0;
         rsp_rdata      <= '0;
         rsp_err        <= 1'b0;
         m_axil_awaddr  <= '0;
         m_axil_awvalid <= 1'b0;
         m_axil_wdata   <= '0;
         m_axil_wstrb   <= '0;
         m_axil_wvalid  <= 1'b0;
         m_axil_bready  <= 1'b0;
         m_axil_araddr  <= '0;
         m_axil_arvalid <= 1'b0;
         m_axil_rready  <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (sel_found) begin
                  grant_reg <= sel_idx;
                  if (req_we[sel_idx]) begin
                     m_axil_awaddr  <= addr_arr[sel_idx];
                     m_axil_wdata   <= wdata_arr[sel_idx];
                     m_axil_wstrb   <= wstrb_arr[sel_idx];
                     m_axil_awvalid <= 1'b1;
                     m_axil_wvalid  <= 1'b1;
                     state_reg      <= WR_ISSUE;
                  end else begin
                     m_axil_araddr  <= addr_arr[sel_idx];
                     m_axil_arvalid <= 1'b1;
                     state_reg      <= RD_ISSUE;
                  end
               end
            end
            WR_ISSUE: begin
               // AW and W complete independently; move on once neither is still pending.
               if (m_axil_awready) m_axil_awvalid <= 1'b0;
               if (m_axil_wready)  m_axil_wvalid  <= 1'b0;
               if ((!m_axil_awvalid || m_axil_awready) && (!m_axil_wvalid || m_axil_wready)) begin
                  m_axil_bready <= 1'b1;
                  state_reg     <= WR_RESP;
               end
            end
            WR_RESP: begin
               if (m_axil_bvalid) begin
                  m_axil_bready <= 1'b0;
                  rsp_err       <= (m_axil_bresp != 2'b00);
                  rsp_valid_reg <= 1'b1;
                  state_reg     <= RESP;
               end
            end
            RD_ISSUE: begin
               if (m_axil_arready) begin
                  m_axil_arvalid <= 1'b0;
                  m_axil_rready  <= 1'b1;
                  state_reg      <= RD_DATA;
               end
            end
            RD_DATA: begin
               if (m_axil_rvalid) begin
                  m_axil_rready <= 1'b0;
                  rsp_rdata     <= m_axil_rdata;
                  rsp_err       <= (m_axil_rresp != 2'b00);
                  rsp_valid_reg <= 1'b1;
                  state_reg     <= RESP;
               end
            end
            RESP: begin
               if (rsp_ready[grant_reg]) begin
                  rsp_valid_reg <= 1'b0;
                  last_reg      <= grant_reg;
                  state_reg     <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule
